// File: rtl/fft_pkg.sv
// Shared types and default sizes for the in-place radix-2 DIT FFT sequencer.
package fft_pkg;

  localparam int LOG2N_DEF = 11;
  localparam int N_DEF     = 1 << LOG2N_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fft_state_e;

  typedef logic [LOG2N_DEF-1:0] fft_adr_t;
  typedef logic [LOG2N_DEF-2:0] fft_tw_t;

endpackage

// File: rtl/fft_adr_gen.sv
// Butterfly address generator: maps (stage, butterfly index) to the two
// operand addresses and the twiddle ROM index of an in-place DIT pass.
module fft_adr_gen #(
  parameter int LOG2N = 11,
  parameter int SW    = 4
) (
  input  logic [SW-1:0]    stage_i,
  input  logic [LOG2N-2:0] bfly_i,
  output logic [LOG2N-1:0] adr_a_o,
  output logic [LOG2N-1:0] adr_b_o,
  output logic [LOG2N-2:0] tw_o
);

  localparam int TW = LOG2N - 1;

  logic [LOG2N-1:0] bfly_w_s;
  logic [LOG2N-1:0] lo_s;
  logic [LOG2N-1:0] hi_s;

  // Split the butterfly index around bit 'stage' and insert a zero there for A.
  always_comb begin
    bfly_w_s = {1'b0, bfly_i};
    lo_s     = bfly_w_s & ~({LOG2N{1'b1}} << stage_i);
    hi_s     = bfly_w_s >> stage_i;
    adr_a_o  = ((hi_s << stage_i) << 1'b1) | lo_s;
    adr_b_o  = adr_a_o | (LOG2N'(1) << stage_i);
    // lo << (LOG2N-1-stage), done as a fixed left shift then a right shift
    // in a double-width word so no bits are lost before truncation.
    tw_o     = TW'(({{LOG2N{1'b0}}, lo_s} << (LOG2N - 1)) >> stage_i);
  end

endmodule

// File: rtl/fft_sequencer.sv
// Control sequencer for an in-place radix-2 DIT FFT over two ping-pong RAM
// banks: issues one butterfly per cycle, delays write addresses by the
// datapath latency and drains between stages to avoid read-after-write hazards.
module fft_sequencer
  import fft_pkg::*;
#(
  parameter int LOG2N = LOG2N_DEF,
  parameter int LAT   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             rdsel,
  output logic             we0,
  output logic [LOG2N-1:0] adr0a,
  output logic [LOG2N-1:0] adr0b,
  output logic             we1,
  output logic [LOG2N-1:0] adr1a,
  output logic [LOG2N-1:0] adr1b,
  output logic [LOG2N-2:0] twiddleadr
);

  localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;
  localparam int BW = LOG2N - 1;
  localparam int CW = $clog2(LAT + 1);

  fft_state_e       state_q, state_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic [BW-1:0]    bfly_q, bfly_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [LAT-1:0]   valid_q, valid_d;
  logic [LOG2N-1:0] pa_q [LAT];
  logic [LOG2N-1:0] pa_d [LAT];
  logic [LOG2N-1:0] pb_q [LAT];
  logic [LOG2N-1:0] pb_d [LAT];

  logic [LOG2N-1:0] rda_q, rda_d, rdb_q, rdb_d;
  logic [BW-1:0]    tw_q, tw_d;

  logic             issue_s;
  logic [LOG2N-1:0] gen_a_s, gen_b_s;
  logic [BW-1:0]    gen_tw_s;
  logic [LOG2N-1:0] rd_a_s, rd_b_s, wr_a_s, wr_b_s;
  logic             wr_valid_s;

  fft_adr_gen #(.LOG2N(LOG2N), .SW(SW)) u_adr_gen (
    .stage_i (stage_q),
    .bfly_i  (bfly_q),
    .adr_a_o (gen_a_s),
    .adr_b_o (gen_b_s),
    .tw_o    (gen_tw_s)
  );

  assign issue_s = (state_q == RUN);

  // Next-state logic: stage/butterfly counters and the per-stage drain.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    bfly_d  = bfly_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          stage_d = {SW{1'b0}};
          bfly_d  = {BW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        bfly_d = bfly_q + BW'(1);
        if (&bfly_q) begin
          state_d = DRAIN;
          cnt_d   = CW'(LAT);
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (cnt_q == CW'(1)) begin
          cnt_d = {CW{1'b0}};
          if (stage_q == SW'(LOG2N - 1)) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            stage_d = stage_q + SW'(1);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        stage_d = {SW{1'b0}};
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Write-side delay line; address stages only load when a valid entry moves in,
  // and the read-side/twiddle values hold between issues.
  always_comb begin
    valid_d[0] = issue_s;
    if (issue_s) begin
      pa_d[0] = gen_a_s;
      pb_d[0] = gen_b_s;
      rda_d   = gen_a_s;
      rdb_d   = gen_b_s;
      tw_d    = gen_tw_s;
    end else begin
      pa_d[0] = pa_q[0];
      pb_d[0] = pb_q[0];
      rda_d   = rda_q;
      rdb_d   = rdb_q;
      tw_d    = tw_q;
    end
    for (int i = 1; i < LAT; i++) begin
      valid_d[i] = valid_q[i-1];
      if (valid_q[i-1]) begin
        pa_d[i] = pa_q[i-1];
        pb_d[i] = pb_q[i-1];
      end else begin
        pa_d[i] = pa_q[i];
        pb_d[i] = pb_q[i];
      end
    end
  end

  // State, counters, delay line and held addresses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      stage_q <= {SW{1'b0}};
      bfly_q  <= {BW{1'b0}};
      cnt_q   <= {CW{1'b0}};
      valid_q <= {LAT{1'b0}};
      rda_q   <= {LOG2N{1'b0}};
      rdb_q   <= {LOG2N{1'b0}};
      tw_q    <= {BW{1'b0}};
      for (int i = 0; i < LAT; i++) begin
        pa_q[i] <= {LOG2N{1'b0}};
        pb_q[i] <= {LOG2N{1'b0}};
      end
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      bfly_q  <= bfly_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      rda_q   <= rda_d;
      rdb_q   <= rdb_d;
      tw_q    <= tw_d;
      for (int i = 0; i < LAT; i++) begin
        pa_q[i] <= pa_d[i];
        pb_q[i] <= pb_d[i];
      end
    end
  end

  // Output decode: read bank gets fresh addresses, the other bank the delayed ones.
  always_comb begin
    rd_a_s     = issue_s ? gen_a_s : rda_q;
    rd_b_s     = issue_s ? gen_b_s : rdb_q;
    wr_a_s     = pa_q[LAT-1];
    wr_b_s     = pb_q[LAT-1];
    wr_valid_s = valid_q[LAT-1];
    rdsel      = stage_q[0];
    we0        = wr_valid_s & rdsel;
    we1        = wr_valid_s & ~rdsel;
    adr0a      = rdsel ? wr_a_s : rd_a_s;
    adr0b      = rdsel ? wr_b_s : rd_b_s;
    adr1a      = rdsel ? rd_a_s : wr_a_s;
    adr1b      = rdsel ? rd_b_s : wr_b_s;
    twiddleadr = issue_s ? gen_tw_s : tw_q;
    busy       = (state_q != IDLE);
    done       = (state_q == DONE);
  end

endmodule
